// File: rtl/mem_req_rsp_bridge.sv
// Request/response buffer between one memory master and one memory slave.
// Read credits make sure every issued read already has a response slot reserved.
module mem_req_rsp_bridge #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         m_req_cmd,
  input  logic [ADDR_W-1:0]            m_req_addr,
  input  logic [DATA_W-1:0]            m_req_data,
  input  logic                         m_req_en,
  output logic                         m_req_rdy,
  output logic [DATA_W-1:0]            m_rsp_data,
  output logic                         m_rsp_en,
  input  logic                         m_rsp_rdy,
  output logic                         s_req_cmd,
  output logic [ADDR_W-1:0]            s_req_addr,
  output logic [DATA_W-1:0]            s_req_data,
  output logic                         s_req_en,
  input  logic                         s_req_rdy,
  input  logic [DATA_W-1:0]            s_rsp_data,
  input  logic                         s_rsp_en,
  output logic                         s_rsp_rdy,
  output logic [$clog2(RSP_DEPTH):0]   rd_inflight,
  output logic                         err_unexp
);

  localparam int REQ_AW = $clog2(REQ_DEPTH);
  localparam int RSP_AW = $clog2(RSP_DEPTH);
  localparam int REQ_W  = 1 + ADDR_W + DATA_W;
  localparam int CNT_W  = RSP_AW + 1;

  logic [REQ_W-1:0]  r_req_mem [REQ_DEPTH];
  logic [REQ_AW:0]   r_req_wptr;
  logic [REQ_AW:0]   r_req_rptr;
  logic [DATA_W-1:0] r_rsp_mem [RSP_DEPTH];
  logic [RSP_AW:0]   r_rsp_wptr;
  logic [RSP_AW:0]   r_rsp_rptr;
  logic [CNT_W-1:0]  r_rd_inflight;
  logic              r_m_req_rdy;
  logic              r_s_rsp_rdy;
  logic              r_err_unexp;

  logic [REQ_W-1:0]  w_req_head;
  logic              w_req_empty;
  logic              w_req_push;
  logic              w_req_pop;
  logic [REQ_AW:0]   w_req_wptr_nxt;
  logic [REQ_AW:0]   w_req_rptr_nxt;
  logic              w_req_full_nxt;
  logic              w_rsp_empty;
  logic [CNT_W-1:0]  w_rsp_count;
  logic              w_rsp_unexp;
  logic              w_rsp_push;
  logic              w_rsp_pop;
  logic [RSP_AW:0]   w_rsp_wptr_nxt;
  logic [RSP_AW:0]   w_rsp_rptr_nxt;
  logic              w_rsp_full_nxt;
  logic [CNT_W:0]    w_credit_used;
  logic              w_credit_ok;
  logic              w_rd_issue;
  logic [CNT_W-1:0]  w_inflight_nxt;

  assign w_req_empty = (r_req_wptr == r_req_rptr);
  assign w_req_head  = r_req_mem[r_req_rptr[REQ_AW-1:0]];
  assign w_req_push  = m_req_en && r_m_req_rdy;
  assign w_req_pop   = s_req_en && s_req_rdy;

  assign w_req_wptr_nxt = r_req_wptr + {{REQ_AW{1'b0}}, w_req_push};
  assign w_req_rptr_nxt = r_req_rptr + {{REQ_AW{1'b0}}, w_req_pop};
  assign w_req_full_nxt = (w_req_wptr_nxt[REQ_AW-1:0] == w_req_rptr_nxt[REQ_AW-1:0]) &&
                          (w_req_wptr_nxt[REQ_AW] != w_req_rptr_nxt[REQ_AW]);

  // A read may only leave once responses in flight plus those already buffered leave a free slot.
  assign w_rsp_count   = r_rsp_wptr - r_rsp_rptr;
  assign w_credit_used = {1'b0, r_rd_inflight} + {1'b0, w_rsp_count};
  assign w_credit_ok   = (w_credit_used < (CNT_W + 1)'(RSP_DEPTH));

  assign s_req_en   = !w_req_empty && (!w_req_head[REQ_W-1] || w_credit_ok);
  assign s_req_cmd  = w_req_head[REQ_W-1];
  assign s_req_addr = w_req_head[REQ_W-2 -: ADDR_W];
  assign s_req_data = w_req_head[DATA_W-1:0];
  assign w_rd_issue = w_req_pop && s_req_cmd;

  assign w_rsp_empty = (r_rsp_wptr == r_rsp_rptr);
  assign w_rsp_unexp = s_rsp_en && (r_rd_inflight == {CNT_W{1'b0}});
  assign w_rsp_push  = s_rsp_en && r_s_rsp_rdy && !w_rsp_unexp;
  assign w_rsp_pop   = m_rsp_en && m_rsp_rdy;

  assign w_rsp_wptr_nxt = r_rsp_wptr + {{RSP_AW{1'b0}}, w_rsp_push};
  assign w_rsp_rptr_nxt = r_rsp_rptr + {{RSP_AW{1'b0}}, w_rsp_pop};
  assign w_rsp_full_nxt = (w_rsp_wptr_nxt[RSP_AW-1:0] == w_rsp_rptr_nxt[RSP_AW-1:0]) &&
                          (w_rsp_wptr_nxt[RSP_AW] != w_rsp_rptr_nxt[RSP_AW]);

  assign m_rsp_en    = !w_rsp_empty;
  assign m_rsp_data  = r_rsp_mem[r_rsp_rptr[RSP_AW-1:0]];
  assign m_req_rdy   = r_m_req_rdy;
  assign s_rsp_rdy   = r_s_rsp_rdy;
  assign rd_inflight = r_rd_inflight;
  assign err_unexp   = r_err_unexp;

  // Next reads-in-flight count; simultaneous issue and return cancel out.
  always_comb begin
    w_inflight_nxt = r_rd_inflight;
    case ({w_rd_issue, w_rsp_push})
      2'b10:   w_inflight_nxt = r_rd_inflight + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   w_inflight_nxt = r_rd_inflight - {{(CNT_W-1){1'b0}}, 1'b1};
      default: w_inflight_nxt = r_rd_inflight;
    endcase
  end

  // Request FIFO storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REQ_DEPTH; i++) r_req_mem[i] <= '0;
    end else if (w_req_push) begin
      r_req_mem[r_req_wptr[REQ_AW-1:0]] <= {m_req_cmd, m_req_addr, m_req_data};
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RSP_DEPTH; i++) r_rsp_mem[i] <= '0;
    end else if (w_rsp_push) begin
      r_rsp_mem[r_rsp_wptr[RSP_AW-1:0]] <= s_rsp_data;
    end
  end

  // Pointers, ready flags, credit counter and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req_wptr    <= '0;
      r_req_rptr    <= '0;
      r_rsp_wptr    <= '0;
      r_rsp_rptr    <= '0;
      r_rd_inflight <= '0;
      r_m_req_rdy   <= 1'b0;
      r_s_rsp_rdy   <= 1'b0;
      r_err_unexp   <= 1'b0;
    end else begin
      r_req_wptr    <= w_req_wptr_nxt;
      r_req_rptr    <= w_req_rptr_nxt;
      r_rsp_wptr    <= w_rsp_wptr_nxt;
      r_rsp_rptr    <= w_rsp_rptr_nxt;
      r_rd_inflight <= w_inflight_nxt;
      r_m_req_rdy   <= !w_req_full_nxt;
      r_s_rsp_rdy   <= !w_rsp_full_nxt;
      r_err_unexp   <= r_err_unexp || w_rsp_unexp;
    end
  end

endmodule
